// File: rtl/eth_tx_packetizer.sv
// Buffers 32-bit IQ sample words and emits one Ethernet frame (L2 header,
// sequence number, NUM_SAMPLES payload words) per full payload on the MAC ff_tx port.
module eth_tx_packetizer #(
  parameter int          NUM_SAMPLES = 64,
  parameter int          FIFO_DEPTH  = 256,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02000000A001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] ff_tx_data,
  output logic        ff_tx_sop,
  output logic        ff_tx_eop,
  output logic [1:0]  ff_tx_mod,
  output logic        ff_tx_err,
  output logic        ff_tx_crc_fwd,
  output logic        ff_tx_wren,
  input  logic        ff_tx_rdy,
  output logic [15:0] seq_num,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(NUM_SAMPLES);
  localparam logic [FW-1:0] NS_F    = FW'(NUM_SAMPLES);
  localparam logic [FW-1:0] DEPTH_F = FW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(NUM_SAMPLES - 1);

  localparam logic [31:0] W0 = DST_MAC[47:16];
  localparam logic [31:0] W1 = {DST_MAC[15:0], SRC_MAC[47:32]};
  localparam logic [31:0] W2 = SRC_MAC[31:0];

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  // ---------------- sample FIFO ----------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill, fill_n;
  logic          wr, pop;

  assign wr = s_valid && s_ready;

  always_comb begin
    fill_n = fill;
    case ({wr, pop})
      2'b10:   fill_n = fill + FW'(1);
      2'b01:   fill_n = fill - FW'(1);
      default: fill_n = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s_data;
  end

  // s_ready is a flop of the next fill, so it always mirrors the current fill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      s_ready  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fill    <= fill_n;
      s_ready <= (fill_n < DEPTH_F);
      if (s_valid && !s_ready) overflow <= 1'b1;
      else if (clear_ovf)      overflow <= 1'b0;
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state, state_n;
  logic [1:0]    hdr_idx, hdr_n;
  logic [CW-1:0] pay_cnt, cnt_n;
  logic [31:0]   data_q, data_n;
  logic          sop_q, sop_n, eop_q, eop_n, wren_q, wren_n;
  logic [15:0]   seq_q;
  logic          seq_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      hdr_idx <= '0;
      pay_cnt <= '0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      wren_q  <= 1'b0;
      seq_q   <= '0;
    end else begin
      state   <= state_n;
      hdr_idx <= hdr_n;
      pay_cnt <= cnt_n;
      data_q  <= data_n;
      sop_q   <= sop_n;
      eop_q   <= eop_n;
      wren_q  <= wren_n;
      if (seq_inc) seq_q <= seq_q + 16'd1;
    end
  end

  // Output word is registered; the next payload word is prefetched from
  // the slot behind the head since the head pops on the same transfer.
  always_comb begin
    state_n = state;
    hdr_n   = hdr_idx;
    cnt_n   = pay_cnt;
    data_n  = data_q;
    sop_n   = sop_q;
    eop_n   = eop_q;
    wren_n  = wren_q;
    pop     = 1'b0;
    seq_inc = 1'b0;
    case (state)
      IDLE: begin
        if (enable && fill >= NS_F) begin
          state_n = HDR;
          hdr_n   = '0;
        end
      end
      HDR: begin
        if (!wren_q) begin
          data_n = W0;
          sop_n  = 1'b1;
          wren_n = 1'b1;
          hdr_n  = '0;
        end else if (ff_tx_rdy) begin
          sop_n = 1'b0;
          hdr_n = hdr_idx + 2'd1;
          case (hdr_idx)
            2'd0:    data_n = W1;
            2'd1:    data_n = W2;
            2'd2:    data_n = {ETHERTYPE, seq_q};
            default: begin
              data_n  = mem[rd_ptr];
              state_n = PAY;
              cnt_n   = '0;
              eop_n   = 1'b0;
            end
          endcase
        end
      end
      PAY: begin
        if (ff_tx_rdy) begin
          pop = 1'b1;
          if (pay_cnt == LAST) begin
            state_n = IDLE;
            wren_n  = 1'b0;
            eop_n   = 1'b0;
            data_n  = '0;
            seq_inc = 1'b1;
          end else begin
            cnt_n  = pay_cnt + CW'(1);
            data_n = mem[rd_ptr + AW'(1)];
            eop_n  = (cnt_n == LAST);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ff_tx_data    = data_q;
  assign ff_tx_sop     = sop_q;
  assign ff_tx_eop     = eop_q;
  assign ff_tx_wren    = wren_q;
  assign ff_tx_mod     = 2'b00;
  assign ff_tx_err     = 1'b0;
  assign ff_tx_crc_fwd = 1'b0;
  assign seq_num       = seq_q;

endmodule

// File: tb/tb_eth_tx_packetizer.sv
// Scoreboard bench for eth_tx_packetizer: stimulus pushes expected frame words,
// a negedge monitor pops and compares every MAC transfer.
module tb_eth_tx_packetizer;
  localparam int NS = 16;
  localparam int FD = 32;

  logic        clk = 1'b0;
  logic        reset_n, enable, s_valid, s_ready, clear_ovf;
  logic [31:0] s_data, ff_tx_data;
  logic        ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_crc_fwd, ff_tx_wren, ff_tx_rdy;
  logic [1:0]  ff_tx_mod;
  logic [15:0] seq_num;
  logic        overflow;
  logic        bp = 1'b0;

  eth_tx_packetizer #(.NUM_SAMPLES(NS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .ff_tx_data(ff_tx_data),
    .ff_tx_sop(ff_tx_sop), .ff_tx_eop(ff_tx_eop), .ff_tx_mod(ff_tx_mod),
    .ff_tx_err(ff_tx_err), .ff_tx_crc_fwd(ff_tx_crc_fwd), .ff_tx_wren(ff_tx_wren),
    .ff_tx_rdy(ff_tx_rdy), .seq_num(seq_num), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_seq = 16'd0;

  // MAC ready: constant 1, or a pseudo-random pattern during backpressure
  initial ff_tx_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    ff_tx_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: stability under backpressure, then scoreboard compare on transfer
  logic        hold_prev = 1'b0;
  logic [34:0] prev = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (hold_prev) begin
        checks++;
        if ({ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren} !== prev) begin
          errors++;
          $display("FAIL hold_stable got=%h required=%h", {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren}, prev);
        end
      end
      if (ff_tx_wren && ff_tx_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got data=%h sop=%b eop=%b, required no transfer", ff_tx_data, ff_tx_sop, ff_tx_eop);
        end else begin
          e = exp_q.pop_front();
          if (ff_tx_data !== e.d || ff_tx_sop !== e.sop || ff_tx_eop !== e.eop ||
              ff_tx_mod !== 2'b00 || ff_tx_err !== 1'b0 || ff_tx_crc_fwd !== 1'b0) begin
            errors++;
            $display("FAIL frame_word got data=%h sop=%b eop=%b mod=%0d, required data=%h sop=%b eop=%b mod=0",
                     ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, e.d, e.sop, e.eop);
          end
        end
      end
      hold_prev = ff_tx_wren && !ff_tx_rdy;
      prev      = {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic push_frame(input int first);
    exp_q.push_back('{32'hFFFFFFFF, 1'b1, 1'b0});
    exp_q.push_back('{32'hFFFF0200, 1'b0, 1'b0});
    exp_q.push_back('{32'h0000A001, 1'b0, 1'b0});
    exp_q.push_back('{{16'h88B5, exp_seq}, 1'b0, 1'b0});
    for (int i = 0; i < NS; i++)
      exp_q.push_back('{32'(first + i), 1'b0, (i == NS - 1)});
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic put(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic put_range(input int first, input int last);
    for (int i = first; i <= last; i++) put(32'(i));
  endtask

  task automatic drain(input string nm, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout remaining_words=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; clear_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wren", 32'(ff_tx_wren), 32'd0);
    chk("rst_sop", 32'(ff_tx_sop), 32'd0);
    chk("rst_eop", 32'(ff_tx_eop), 32'd0);
    chk("rst_data", ff_tx_data, 32'd0);
    chk("rst_seq", 32'(seq_num), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // basic frame
    enable = 1'b1;
    push_frame(1);
    put_range(1, 16);
    drain("basic", 200);
    chk("basic_seq", 32'(seq_num), 32'd1);

    // backpressure
    bp = 1'b1;
    push_frame(1);
    put_range(1, 16);
    drain("bp", 800);
    bp = 1'b0;
    chk("bp_seq", 32'(seq_num), 32'd2);

    // overflow
    enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    put_range(1, 32);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_ovf", 32'(overflow), 32'd0);
    put(32'd33);
    chk("ovf_set", 32'(overflow), 32'd1);
    push_frame(1);
    push_frame(17);
    enable = 1'b1;
    drain("ovf_frames", 400);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_ready", 32'(s_ready), 32'd1);
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // sequence wrap via backdoor preload
    enable = 1'b0;
    force dut.seq_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.seq_q;
    exp_seq = 16'hFFFF;
    push_frame(1);
    push_frame(17);
    enable = 1'b1;
    put_range(1, 32);
    drain("wrap", 400);
    chk("wrap_seq", 32'(seq_num), 32'd1);

    // enable dropped during W2: frame completes, no further frame
    enable = 1'b0;
    put_range(1, 32);
    push_frame(1);
    enable = 1'b1;
    begin
      int n = 0;
      while (!(ff_tx_wren && ff_tx_data == 32'h0000A001) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("saw_w2", 32'(ff_tx_wren && ff_tx_data == 32'h0000A001), 32'd1);
    end
    enable = 1'b0;
    drain("en_drop", 200);
    repeat (40) @(posedge clk);
    #1;
    chk("en_hold_wren", 32'(ff_tx_wren), 32'd0);
    chk("en_hold_seq", 32'(seq_num), 32'(exp_seq));

    // reset mid-payload (remaining words 17..32 are still buffered)
    push_frame(17);
    enable = 1'b1;
    begin
      int n = 0;
      while (!(ff_tx_wren && ff_tx_data == 32'd21) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("saw_payload", 32'(ff_tx_wren && ff_tx_data == 32'd21), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(ff_tx_wren), 32'd0);
    chk("mid_rst_sop", 32'(ff_tx_sop), 32'd0);
    chk("mid_rst_eop", 32'(ff_tx_eop), 32'd0);
    chk("mid_rst_seq", 32'(seq_num), 32'd0);
    exp_q.delete();
    exp_seq = 16'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_idle", 32'(ff_tx_wren), 32'd0);
    push_frame(1);
    put_range(1, 16);
    drain("post_rst", 200);

    // threshold: 15 words hold, 16th gives sop two cycles later
    push_frame(101);
    put_range(101, 115);
    repeat (10) @(posedge clk);
    #1;
    chk("thr15_wren", 32'(ff_tx_wren), 32'd0);
    put(32'd116);
    chk("thr_sop_c0", 32'(ff_tx_sop), 32'd0);
    @(posedge clk); #1;
    chk("thr_sop_c1", 32'(ff_tx_sop), 32'd0);
    @(posedge clk); #1;
    chk("thr_sop_c2", 32'(ff_tx_sop), 32'd1);
    drain("thr", 200);
    chk("thr_seq", 32'(seq_num), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
